// File: rtl/timer_counter.sv
// rtl/timer_counter.sv - memory-mapped 32-bit down-counter timer with one-shot / auto-reload modes
// Optional prescaler on CTRL[7:4] is built only when TIMER_PRESCALE_EN is defined.
module timer_counter #(
  parameter int CNT_W = 32
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [29:0] Addr,
  input  logic        WE,
  input  logic [31:0] Din,
  output logic [31:0] Dout,
  output logic        IRQ
);

  localparam logic [1:0] A_CTRL   = 2'd0;
  localparam logic [1:0] A_PRESET = 2'd1;
  localparam logic [1:0] A_COUNT  = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_CNT,
    ST_INT
  } state_t;

  state_t           state;
  state_t           state_next;
  logic             ctrl_en;
  logic [1:0]       ctrl_mode;
  logic             ctrl_im;
  logic [CNT_W-1:0] preset;
  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] count_next;
  logic             irq_flag;

  logic             wr_ctrl;
  logic             wr_preset;
  logic             auto_reload;
  logic             tick;
  logic             en_clr;
  logic             flag_set;
  logic             flag_clr;
  logic [31:0]      preset_ext;
  logic [31:0]      count_ext;
  logic [3:0]       ps_field;
  logic             unused_bits;

  assign wr_ctrl     = WE && (Addr[1:0] == A_CTRL);
  assign wr_preset   = WE && (Addr[1:0] == A_PRESET);
  // Reserved mode encodings 1x fall back to one-shot.
  assign auto_reload = (ctrl_mode == 2'b01);
  assign unused_bits = ^{Addr[29:2], Din};

`ifdef TIMER_PRESCALE_EN
  logic [3:0] ctrl_ps;
  logic [3:0] psc;
  logic [3:0] psc_next;

  assign tick     = (psc == ctrl_ps);
  assign ps_field = ctrl_ps;
`else
  assign tick     = 1'b1;
  assign ps_field = 4'd0;
`endif

  always_comb begin
    state_next = state;
    count_next = count;
    en_clr     = 1'b0;
    flag_set   = 1'b0;
    flag_clr   = 1'b0;
`ifdef TIMER_PRESCALE_EN
    psc_next   = psc;
`endif
    case (state)
      ST_IDLE: begin
`ifdef TIMER_PRESCALE_EN
        psc_next = 4'd0;
`endif
        if (ctrl_en) begin
          state_next = ST_LOAD;
        end
      end
      ST_LOAD: begin
`ifdef TIMER_PRESCALE_EN
        psc_next = 4'd0;
`endif
        count_next = preset;
        state_next = ST_CNT;
      end
      ST_CNT: begin
        if (!ctrl_en) begin
          state_next = ST_IDLE;
        end else if (tick) begin
`ifdef TIMER_PRESCALE_EN
          psc_next = 4'd0;
`endif
          if (count == '0) begin
            state_next = ST_INT;
            flag_set   = 1'b1;
          end else begin
            count_next = count - CNT_W'(1);
          end
        end else begin
`ifdef TIMER_PRESCALE_EN
          psc_next = psc + 4'd1;
`endif
        end
      end
      ST_INT: begin
        if (auto_reload) begin
          state_next = ST_LOAD;
          flag_clr   = 1'b1;
        end else begin
          state_next = ST_IDLE;
          en_clr     = 1'b1;
        end
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= ST_IDLE;
      count <= '0;
`ifdef TIMER_PRESCALE_EN
      psc   <= 4'd0;
`endif
    end else begin
      state <= state_next;
      count <= count_next;
`ifdef TIMER_PRESCALE_EN
      psc   <= psc_next;
`endif
    end
  end

  // A bus write to CTRL overrides the FSM's own EN clear in the same cycle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ctrl_en   <= 1'b0;
      ctrl_mode <= 2'b00;
      ctrl_im   <= 1'b0;
`ifdef TIMER_PRESCALE_EN
      ctrl_ps   <= 4'd0;
`endif
    end else if (wr_ctrl) begin
      ctrl_en   <= Din[0];
      ctrl_mode <= Din[2:1];
      ctrl_im   <= Din[3];
`ifdef TIMER_PRESCALE_EN
      ctrl_ps   <= Din[7:4];
`endif
    end else if (en_clr) begin
      ctrl_en <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      preset <= '0;
    end else if (wr_preset) begin
      preset <= Din[CNT_W-1:0];
    end
  end

  // Setting the flag beats any clear so an expiry coinciding with a CTRL write is kept.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      irq_flag <= 1'b0;
    end else if (flag_set) begin
      irq_flag <= 1'b1;
    end else if (wr_ctrl || flag_clr) begin
      irq_flag <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      IRQ <= 1'b0;
    end else begin
      IRQ <= irq_flag & ctrl_im;
    end
  end

  always_comb begin
    preset_ext              = '0;
    preset_ext[CNT_W-1:0]   = preset;
    count_ext               = '0;
    count_ext[CNT_W-1:0]    = count;
  end

  always_comb begin
    Dout = 32'd0;
    case (Addr[1:0])
      A_CTRL:   Dout = {24'd0, ps_field, ctrl_im, ctrl_mode, ctrl_en};
      A_PRESET: Dout = preset_ext;
      A_COUNT:  Dout = count_ext;
      default:  Dout = 32'd0;
    endcase
  end

endmodule

// File: tb/tb_timer_counter.sv
// tb/tb_timer_counter.sv - self-checking bench for timer_counter (register table plus scoreboarded timing sequences)
`timescale 1ns/100ps
module tb_timer_counter;

  logic        clk;
  logic        reset_n;
  logic [29:0] Addr;
  logic        WE;
  logic [31:0] Din;
  logic [31:0] Dout;
  logic        IRQ;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  timer_counter #(.CNT_W(32)) dut (
    .clk(clk),
    .reset_n(reset_n),
    .Addr(Addr),
    .WE(WE),
    .Din(Din),
    .Dout(Dout),
    .IRQ(IRQ)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  typedef struct {
    int          due;
    bit          is_irq;
    logic [1:0]  addr;
    logic [31:0] val;
    string       name;
  } exp_t;

  typedef struct {
    logic        we;
    logic [1:0]  addr;
    logic [31:0] din;
    logic [1:0]  rd_addr;
    logic [31:0] rd_val;
    string       name;
  } vec_t;

  exp_t exp_q[$];
  vec_t vecs[8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, want, cyc);
    end
  endtask

  task automatic push_irq(input int due, input logic val, input string name);
    exp_t e;
    e.due = due; e.is_irq = 1'b1; e.addr = 2'd0; e.val = {31'd0, val}; e.name = name;
    exp_q.push_back(e);
  endtask

  task automatic push_reg(input int due, input logic [1:0] addr, input logic [31:0] val, input string name);
    exp_t e;
    e.due = due; e.is_irq = 1'b0; e.addr = addr; e.val = val; e.name = name;
    exp_q.push_back(e);
  endtask

  task automatic read_chk(input logic [1:0] addr, input logic [31:0] want, input string name);
    Addr = {28'd0, addr};
    #1;
    chk(name, Dout, want);
  endtask

  task automatic sample();
    exp_t keep[$];
    WE = 1'b0;
    for (int i = 0; i < exp_q.size(); i++) begin
      if (exp_q[i].due == cyc) begin
        if (exp_q[i].is_irq) chk(exp_q[i].name, {31'd0, IRQ}, exp_q[i].val);
        else read_chk(exp_q[i].addr, exp_q[i].val, exp_q[i].name);
      end else begin
        keep.push_back(exp_q[i]);
      end
    end
    exp_q = keep;
  endtask

  task automatic step(input logic we, input logic [1:0] addr, input logic [31:0] din);
    @(negedge clk);
    WE = we; Addr = {28'd0, addr}; Din = din;
    @(posedge clk);
    cyc++;
    #1;
    sample();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 2'd0, 32'd0);
  endtask

  initial begin
    int t;
    reset_n = 1'b0; WE = 1'b0; Addr = '0; Din = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;

    // Reset values hold for 20 quiet cycles.
    for (int k = 1; k <= 20; k++) begin
      push_irq(k, 1'b0, "rst_irq");
      push_reg(k, 2'd0, 32'd0, "rst_ctrl");
      push_reg(k, 2'd1, 32'd0, "rst_preset");
      push_reg(k, 2'd2, 32'd0, "rst_count");
    end
    idle(20);

    // Register access table: one bus cycle each, read back after the edge.
    vecs[0] = '{1'b1, 2'd1, 32'h1234_5678, 2'd1, 32'h1234_5678, "tbl_preset_wr"};
    vecs[1] = '{1'b1, 2'd2, 32'h0000_ffff, 2'd2, 32'h0000_0000, "tbl_count_ro"};
    vecs[2] = '{1'b1, 2'd3, 32'hdead_beef, 2'd3, 32'h0000_0000, "tbl_addr3_zero"};
    vecs[3] = '{1'b1, 2'd3, 32'hdead_beef, 2'd1, 32'h1234_5678, "tbl_addr3_nochg"};
    vecs[4] = '{1'b1, 2'd0, 32'hffff_fff6, 2'd0, 32'h0000_0006, "tbl_ctrl_mask"};
    vecs[5] = '{1'b0, 2'd0, 32'hffff_ffff, 2'd1, 32'h1234_5678, "tbl_no_we"};
    vecs[6] = '{1'b1, 2'd0, 32'h0000_0000, 2'd0, 32'h0000_0000, "tbl_ctrl_clr"};
    vecs[7] = '{1'b1, 2'd1, 32'h0000_0000, 2'd1, 32'h0000_0000, "tbl_preset_clr"};
    for (int i = 0; i < 8; i++) begin
      push_reg(cyc + 1, vecs[i].rd_addr, vecs[i].rd_val, vecs[i].name);
      push_irq(cyc + 1, 1'b0, "tbl_irq");
      step(vecs[i].we, vecs[i].addr, vecs[i].din);
    end

    // One-shot, PRESET=5.
    step(1'b1, 2'd1, 32'd5);
    step(1'b1, 2'd0, 32'h9);
    t = cyc;
    push_reg(t + 2, 2'd2, 32'd5, "os_count_load");
    push_reg(t + 3, 2'd2, 32'd4, "os_count_dec");
    push_reg(t + 7, 2'd2, 32'd0, "os_count_zero");
    push_irq(t + 8, 1'b0, "os_irq_early");
    push_reg(t + 8, 2'd0, 32'h9, "os_ctrl_before");
    for (int k = 9; k <= 12; k++) push_irq(t + k, 1'b1, "os_irq_high");
    push_reg(t + 9, 2'd0, 32'h8, "os_ctrl_en_clr");
    push_reg(t + 12, 2'd2, 32'd0, "os_no_wrap");
    idle(12);
    push_irq(cyc + 1, 1'b1, "os_irq_hold");
    push_irq(cyc + 2, 1'b0, "os_irq_drop");
    step(1'b1, 2'd0, 32'h0);
    idle(2);

    // Auto-reload, PRESET=2 (period 5), then PRESET=4 mid-count (period 7).
    step(1'b1, 2'd1, 32'd2);
    step(1'b1, 2'd0, 32'hB);
    t = cyc;
    for (int k = 1; k <= 41; k++)
      push_irq(t + k, (k == 6 || k == 11 || k == 16 || k == 21 || k == 26 || k == 33 || k == 40), "ar_irq");
    for (int k = 1; k <= 41; k++) begin
      if (k == 23) step(1'b1, 2'd1, 32'd4);
      else step(1'b0, 2'd0, 32'd0);
    end
    push_irq(cyc + 2, 1'b0, "ar_off");
    push_irq(cyc + 3, 1'b0, "ar_off");
    step(1'b1, 2'd0, 32'h0);
    idle(3);

    // Disable mid-count, then re-enable reloads PRESET.
    step(1'b1, 2'd1, 32'd100);
    step(1'b1, 2'd0, 32'h9);
    t = cyc;
    push_reg(t + 42, 2'd2, 32'd60, "dis_count60");
    push_reg(t + 44, 2'd2, 32'd59, "dis_frozen");
    push_reg(t + 50, 2'd2, 32'd59, "dis_frozen_late");
    push_irq(t + 44, 1'b0, "dis_no_irq");
    push_irq(t + 50, 1'b0, "dis_no_irq");
    for (int k = 1; k <= 50; k++) begin
      if (k == 43) step(1'b1, 2'd0, 32'h0);
      else step(1'b0, 2'd0, 32'd0);
    end
    t = cyc + 1;
    push_reg(t + 1, 2'd2, 32'd59, "reen_pre_load");
    push_reg(t + 2, 2'd2, 32'd100, "reen_reload");
    push_reg(t + 3, 2'd2, 32'd99, "reen_dec");
    step(1'b1, 2'd0, 32'h9);
    idle(3);
    step(1'b1, 2'd0, 32'h0);
    idle(3);

    // PRESET=0 one-shot: IRQ four edges after enable.
    step(1'b1, 2'd1, 32'd0);
    step(1'b1, 2'd0, 32'h9);
    t = cyc;
    push_reg(t + 2, 2'd2, 32'd0, "p0_count");
    push_irq(t + 3, 1'b0, "p0_irq_pre");
    push_irq(t + 4, 1'b1, "p0_irq");
    idle(4);
    step(1'b1, 2'd0, 32'h0);
    idle(3);

    // IM=0: expiry clears EN but IRQ never rises.
    step(1'b1, 2'd1, 32'd1);
    step(1'b1, 2'd0, 32'h1);
    t = cyc;
    for (int k = 1; k <= 8; k++) push_irq(t + k, 1'b0, "im0_irq");
    push_reg(t + 4, 2'd0, 32'h1, "im0_ctrl_en");
    push_reg(t + 5, 2'd0, 32'h0, "im0_ctrl_done");
    idle(8);

    // CTRL write on the INT-entry edge: the flag set wins.
    step(1'b1, 2'd1, 32'd2);
    step(1'b1, 2'd0, 32'h9);
    t = cyc;
    push_irq(t + 5, 1'b0, "sw_irq_pre");
    push_irq(t + 6, 1'b1, "sw_set_wins");
    push_irq(t + 8, 1'b1, "sw_set_hold");
    push_reg(t + 6, 2'd0, 32'h8, "sw_ctrl");
    for (int k = 1; k <= 8; k++) begin
      if (k == 5) step(1'b1, 2'd0, 32'h8);
      else step(1'b0, 2'd0, 32'd0);
    end
    step(1'b1, 2'd0, 32'h0);
    idle(2);

    // CTRL write on the one-shot EN-clear edge: the written value wins.
    step(1'b1, 2'd1, 32'd2);
    step(1'b1, 2'd0, 32'h9);
    t = cyc;
    push_reg(t + 6, 2'd0, 32'h9, "ww_ctrl_wins");
    push_irq(t + 6, 1'b1, "ww_irq1");
    push_irq(t + 7, 1'b0, "ww_irq_clr");
    push_reg(t + 8, 2'd2, 32'd2, "ww_reload");
    push_irq(t + 11, 1'b0, "ww_irq_pre2");
    push_irq(t + 12, 1'b1, "ww_irq2");
    for (int k = 1; k <= 12; k++) begin
      if (k == 6) step(1'b1, 2'd0, 32'h9);
      else step(1'b0, 2'd0, 32'd0);
    end

    // Asynchronous reset while IRQ is asserted.
    step(1'b1, 2'd1, 32'd7);
    @(negedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    chk("arst_irq", {31'd0, IRQ}, 32'd0);
    read_chk(2'd0, 32'd0, "arst_ctrl");
    read_chk(2'd1, 32'd0, "arst_preset");
    read_chk(2'd2, 32'd0, "arst_count");
    @(negedge clk);
    reset_n = 1'b1;
    push_irq(cyc + 2, 1'b0, "arst_after");
    push_reg(cyc + 2, 2'd0, 32'd0, "arst_ctrl_after");
    idle(3);

    while (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      checks++;
      errors++;
      $display("FAIL %s: never compared, due cycle %0d, final cycle %0d", e.name, e.due, cyc);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: cycle %0d reached time limit", cyc);
    $fatal(1, "watchdog");
  end

endmodule
